// File: rtl/cache_arbiter_rr.sv
// Arbitrates line read/write requests from several L1 ports onto one downstream memory port.
// One transaction at a time: IDLE picks a port, BUSY waits for pmem_resp, RECOVER gives the port a cycle to drop its request.
module cache_arbiter_rr #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int RR_MODE    = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PORTS-1:0]             port_read,
    input  logic [NUM_PORTS-1:0]             port_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  port_wdata,
    output logic [NUM_PORTS-1:0]             port_resp,
    output logic [LINE_WIDTH-1:0]            port_rdata,
    output logic                             pmem_read,
    output logic                             pmem_write,
    output logic [ADDR_WIDTH-1:0]            pmem_address,
    output logic [LINE_WIDTH-1:0]            pmem_wdata,
    input  logic                             pmem_resp,
    input  logic [LINE_WIDTH-1:0]            pmem_rdata
);

    localparam int PTR_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RECOVER
    } state_t;

    state_t                state;
    state_t                next_state;

    logic [NUM_PORTS-1:0]  grant;
    logic                  op_write;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [PTR_WIDTH-1:0]  rr_ptr;

    logic [NUM_PORTS-1:0]  port_req;
    logic                  any_req;
    logic [PTR_WIDTH:0]    scan_idx;
    logic [PTR_WIDTH:0]    next_ptr_w;
    logic [PTR_WIDTH-1:0]  sel_idx;
    logic [PTR_WIDTH-1:0]  sel_next_ptr;
    logic [NUM_PORTS-1:0]  sel_onehot;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LINE_WIDTH-1:0] sel_wdata;

    assign port_req = port_read | port_write;
    assign any_req  = |port_req;

    // Scanning offsets from high to low lets the hit closest to rr_ptr (in wrap order) win last.
    always_comb begin
        sel_idx      = '0;
        scan_idx     = '0;
        next_ptr_w   = '0;
        sel_next_ptr = '0;
        if (RR_MODE != 0) begin
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                scan_idx = {1'b0, rr_ptr} + (PTR_WIDTH+1)'(k);
                if (scan_idx >= (PTR_WIDTH+1)'(NUM_PORTS)) begin
                    scan_idx = scan_idx - (PTR_WIDTH+1)'(NUM_PORTS);
                end
                if (port_req[scan_idx[PTR_WIDTH-1:0]]) begin
                    sel_idx = scan_idx[PTR_WIDTH-1:0];
                end
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (port_req[i]) begin
                    sel_idx = PTR_WIDTH'(i);
                end
            end
        end
        next_ptr_w = {1'b0, sel_idx} + (PTR_WIDTH+1)'(1);
        if (next_ptr_w < (PTR_WIDTH+1)'(NUM_PORTS)) begin
            sel_next_ptr = next_ptr_w[PTR_WIDTH-1:0];
        end
    end

    always_comb begin
        sel_onehot = '0;
        sel_write  = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_idx == PTR_WIDTH'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_write     = port_write[i];
                sel_addr      = port_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata     = port_wdata[i*LINE_WIDTH +: LINE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req)   next_state = BUSY;
            BUSY:    if (pmem_resp) next_state = RECOVER;
            RECOVER: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The winning request is captured whole, so port inputs are don't-care until the next IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant    <= '0;
            op_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rr_ptr   <= '0;
        end else if (state == IDLE && any_req) begin
            grant    <= sel_onehot;
            op_write <= sel_write;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            if (RR_MODE != 0) begin
                rr_ptr <= sel_next_ptr;
            end
        end
    end

    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        port_resp  = '0;
        if (state == BUSY) begin
            pmem_read  = !op_write;
            pmem_write = op_write;
            if (pmem_resp) begin
                port_resp = grant;
            end
        end
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign port_rdata   = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter_rr.sv
// Directed bench for cache_arbiter_rr: a 2-port round-robin instance driven from a vector table,
// and a 4-port fixed-priority instance for the priority sequence.
module tb_cache_arbiter_rr;

    logic clk;
    logic reset_n;

    logic [1:0]   a_port_read;
    logic [1:0]   a_port_write;
    logic [31:0]  a_port_address;
    logic [255:0] a_port_wdata;
    logic [1:0]   a_port_resp;
    logic [127:0] a_port_rdata;
    logic         a_pmem_read;
    logic         a_pmem_write;
    logic [15:0]  a_pmem_address;
    logic [127:0] a_pmem_wdata;
    logic         a_pmem_resp;
    logic [127:0] a_pmem_rdata;

    logic [3:0]   b_port_read;
    logic [3:0]   b_port_write;
    logic [63:0]  b_port_address;
    logic [511:0] b_port_wdata;
    logic [3:0]   b_port_resp;
    logic [127:0] b_port_rdata;
    logic         b_pmem_read;
    logic         b_pmem_write;
    logic [15:0]  b_pmem_address;
    logic [127:0] b_pmem_wdata;
    logic         b_pmem_resp;
    logic [127:0] b_pmem_rdata;

    int n_compared;
    int n_mismatched;

    cache_arbiter_rr #(
        .NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(1)
    ) dut_rr (
        .clk(clk), .reset_n(reset_n),
        .port_read(a_port_read), .port_write(a_port_write),
        .port_address(a_port_address), .port_wdata(a_port_wdata),
        .port_resp(a_port_resp), .port_rdata(a_port_rdata),
        .pmem_read(a_pmem_read), .pmem_write(a_pmem_write),
        .pmem_address(a_pmem_address), .pmem_wdata(a_pmem_wdata),
        .pmem_resp(a_pmem_resp), .pmem_rdata(a_pmem_rdata)
    );

    cache_arbiter_rr #(
        .NUM_PORTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(0)
    ) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .port_read(b_port_read), .port_write(b_port_write),
        .port_address(b_port_address), .port_wdata(b_port_wdata),
        .port_resp(b_port_resp), .port_rdata(b_port_rdata),
        .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
        .pmem_address(b_pmem_address), .pmem_wdata(b_pmem_wdata),
        .pmem_resp(b_pmem_resp), .pmem_rdata(b_pmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   rd;
        logic [1:0]   wr;
        logic [15:0]  addr0;
        logic [15:0]  addr1;
        logic [127:0] wd0;
        logic [127:0] wd1;
        int           lat;
        logic [127:0] rdata;
        logic [1:0]   exp_resp;
        logic         exp_rd;
        logic         exp_wr;
        logic [15:0]  exp_addr;
        logic [127:0] exp_wdata;
        bit           scramble;
    } vec_t;

    vec_t vecs[6];

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        a_port_read    = '0;
        a_port_write   = '0;
        a_port_address = '0;
        a_port_wdata   = '0;
        a_pmem_resp    = 1'b0;
        a_pmem_rdata   = '0;
        b_port_read    = '0;
        b_port_write   = '0;
        b_port_address = '0;
        b_port_wdata   = '0;
        b_pmem_resp    = 1'b0;
        b_pmem_rdata   = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Waits for the downstream strobe, holds it for lat cycles and pulses pmem_resp in the last one.
    // Returns at the negedge of the RECOVER cycle.
    task automatic serve(input bit use_b, input int lat, input logic [127:0] rdata, input bit scramble,
                         output logic [3:0] resp, output logic [127:0] rdata_seen, output int strobes,
                         output logic rd_s, output logic wr_s, output logic [15:0] addr_s,
                         output logic [127:0] wd_s);
        int   waited;
        logic stb;
        waited     = 0;
        strobes    = 0;
        resp       = '0;
        rdata_seen = '0;
        rd_s       = 1'b0;
        wr_s       = 1'b0;
        addr_s     = '0;
        wd_s       = '0;
        @(negedge clk);
        stb = use_b ? (b_pmem_read | b_pmem_write) : (a_pmem_read | a_pmem_write);
        while (!stb && waited < 20) begin
            @(negedge clk);
            waited++;
            stb = use_b ? (b_pmem_read | b_pmem_write) : (a_pmem_read | a_pmem_write);
        end
        check_output("strobe_latency", waited, 0);
        if (!stb) return;
        if (scramble) begin
            a_port_address = ~a_port_address;
            a_port_wdata   = ~a_port_wdata;
        end
        for (int c = 0; c < lat; c++) begin
            if (use_b ? (b_pmem_read | b_pmem_write) : (a_pmem_read | a_pmem_write)) strobes++;
            if (c == lat - 1) begin
                if (use_b) begin
                    b_pmem_resp  = 1'b1;
                    b_pmem_rdata = rdata;
                end else begin
                    a_pmem_resp  = 1'b1;
                    a_pmem_rdata = rdata;
                end
                #1;
                resp       = use_b ? b_port_resp : {2'b00, a_port_resp};
                rdata_seen = use_b ? b_port_rdata : a_port_rdata;
                rd_s       = use_b ? b_pmem_read : a_pmem_read;
                wr_s       = use_b ? b_pmem_write : a_pmem_write;
                addr_s     = use_b ? b_pmem_address : a_pmem_address;
                wd_s       = use_b ? b_pmem_wdata : a_pmem_wdata;
            end
            @(negedge clk);
        end
        a_pmem_resp = 1'b0;
        b_pmem_resp = 1'b0;
    endtask

    task automatic expect_txn(input string name, input bit use_b, input int lat, input logic [127:0] rdata,
                              input logic [3:0] exp_resp, input logic [15:0] exp_addr);
        logic [3:0]   resp;
        logic [127:0] rd_seen;
        int           strobes;
        logic         rd_s;
        logic         wr_s;
        logic [15:0]  addr_s;
        logic [127:0] wd_s;
        serve(use_b, lat, rdata, 1'b0, resp, rd_seen, strobes, rd_s, wr_s, addr_s, wd_s);
        check_output({name, "_resp"}, resp, exp_resp);
        check_output({name, "_addr"}, addr_s, exp_addr);
    endtask

    task automatic apply_stimulus(input string name, input vec_t v);
        logic [3:0]   resp;
        logic [127:0] rd_seen;
        int           strobes;
        logic         rd_s;
        logic         wr_s;
        logic [15:0]  addr_s;
        logic [127:0] wd_s;
        a_port_read    = v.rd;
        a_port_write   = v.wr;
        a_port_address = {v.addr1, v.addr0};
        a_port_wdata   = {v.wd1, v.wd0};
        serve(1'b0, v.lat, v.rdata, v.scramble, resp, rd_seen, strobes, rd_s, wr_s, addr_s, wd_s);
        check_output({name, "_resp"}, resp, {2'b00, v.exp_resp});
        check_output({name, "_pmem_read"}, rd_s, v.exp_rd);
        check_output({name, "_pmem_write"}, wr_s, v.exp_wr);
        check_output({name, "_addr"}, addr_s, v.exp_addr);
        check_output({name, "_wdata"}, wd_s, v.exp_wdata);
        check_output({name, "_rdata"}, rd_seen, v.rdata);
        check_output({name, "_strobe_cycles"}, strobes, v.lat);
        a_pmem_resp = 1'b1;
        #1;
        check_output({name, "_recover_resp"}, a_port_resp, 2'b00);
        check_output({name, "_recover_strobe"}, {a_pmem_read, a_pmem_write}, 2'b00);
        check_output({name, "_recover_addr_hold"}, a_pmem_address, v.exp_addr);
        a_pmem_resp  = 1'b0;
        a_port_read  = '0;
        a_port_write = '0;
        @(negedge clk);
        check_output({name, "_idle_strobe"}, {a_pmem_read, a_pmem_write}, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        vecs[0] = '{rd: 2'b10, wr: 2'b00, addr0: 16'h0000, addr1: 16'h1230, wd0: '0, wd1: '0,
                    lat: 3, rdata: {16{8'hA5}}, exp_resp: 2'b10, exp_rd: 1'b1, exp_wr: 1'b0,
                    exp_addr: 16'h1230, exp_wdata: '0, scramble: 1'b0};
        vecs[1] = '{rd: 2'b01, wr: 2'b01, addr0: 16'h0040, addr1: 16'h0000, wd0: {16{8'hFF}}, wd1: '0,
                    lat: 1, rdata: {16{8'h5A}}, exp_resp: 2'b01, exp_rd: 1'b0, exp_wr: 1'b1,
                    exp_addr: 16'h0040, exp_wdata: {16{8'hFF}}, scramble: 1'b1};
        vecs[2] = '{rd: 2'b11, wr: 2'b00, addr0: 16'h1000, addr1: 16'h2000, wd0: {16{8'h11}}, wd1: {16{8'h22}},
                    lat: 2, rdata: {16{8'h3C}}, exp_resp: 2'b10, exp_rd: 1'b1, exp_wr: 1'b0,
                    exp_addr: 16'h2000, exp_wdata: {16{8'h22}}, scramble: 1'b1};
        vecs[3] = '{rd: 2'b11, wr: 2'b00, addr0: 16'h1000, addr1: 16'h2000, wd0: {16{8'h11}}, wd1: {16{8'h22}},
                    lat: 4, rdata: {16{8'h96}}, exp_resp: 2'b01, exp_rd: 1'b1, exp_wr: 1'b0,
                    exp_addr: 16'h1000, exp_wdata: {16{8'h11}}, scramble: 1'b0};
        vecs[4] = '{rd: 2'b00, wr: 2'b01, addr0: 16'hBEEF, addr1: 16'h0000,
                    wd0: 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, wd1: '0,
                    lat: 2, rdata: {16{8'hC3}}, exp_resp: 2'b01, exp_rd: 1'b0, exp_wr: 1'b1,
                    exp_addr: 16'hBEEF, exp_wdata: 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, scramble: 1'b0};
        vecs[5] = '{rd: 2'b10, wr: 2'b10, addr0: 16'h0000, addr1: 16'hFFFE, wd0: '0, wd1: {8{16'hDEAD}},
                    lat: 1, rdata: {16{8'h0F}}, exp_resp: 2'b10, exp_rd: 1'b0, exp_wr: 1'b1,
                    exp_addr: 16'hFFFE, exp_wdata: {8{16'hDEAD}}, scramble: 1'b0};

        do_reset();
        check_output("reset_a_strobe", {a_pmem_read, a_pmem_write}, 2'b00);
        check_output("reset_a_resp", a_port_resp, 2'b00);
        check_output("reset_a_addr", a_pmem_address, 16'h0000);
        check_output("reset_a_wdata", a_pmem_wdata, 128'h0);
        check_output("reset_b_strobe", {b_pmem_read, b_pmem_write}, 2'b00);
        check_output("reset_b_resp", b_port_resp, 4'b0000);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Both ports read continuously: grants alternate starting at port 0.
        do_reset();
        a_port_read    = 2'b11;
        a_port_address = {16'h0B00, 16'h0A00};
        for (int i = 0; i < 4; i++) begin
            expect_txn($sformatf("rr_contend%0d", i), 1'b0, 2, {16{8'h77}},
                       (i % 2 == 0) ? 4'b0001 : 4'b0010, (i % 2 == 0) ? 16'h0A00 : 16'h0B00);
            @(negedge clk);
        end
        a_port_read = '0;
        @(negedge clk);

        // Fixed priority: port 3 keeps winning over port 0 until it drops.
        b_port_read    = 4'b1001;
        b_port_address = {16'h0300, 16'h0200, 16'h0000, 16'h0100};
        expect_txn("fp_first", 1'b1, 2, {16{8'h44}}, 4'b1000, 16'h0300);
        @(negedge clk);
        expect_txn("fp_again", 1'b1, 1, {16{8'h45}}, 4'b1000, 16'h0300);
        b_port_read = 4'b0001;
        @(negedge clk);
        expect_txn("fp_low", 1'b1, 3, {16{8'h46}}, 4'b0001, 16'h0100);
        b_port_read = 4'b0110;
        b_port_address = {16'h0300, 16'h0222, 16'h0111, 16'h0100};
        @(negedge clk);
        expect_txn("fp_mid", 1'b1, 1, {16{8'h47}}, 4'b0100, 16'h0222);
        b_port_read = '0;
        @(negedge clk);

        // Reset in the middle of BUSY after port 0 moved the pointer to 1.
        do_reset();
        a_port_read    = 2'b01;
        a_port_address = {16'h0D00, 16'h0C00};
        expect_txn("pre_reset", 1'b0, 1, {16{8'h12}}, 4'b0001, 16'h0C00);
        a_port_read = '0;
        @(negedge clk);
        a_port_read = 2'b01;
        @(negedge clk);
        check_output("busy_before_reset", a_pmem_read, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("reset_async_read", a_pmem_read, 1'b0);
        a_pmem_resp = 1'b1;
        #1;
        check_output("reset_no_resp", a_port_resp, 2'b00);
        a_pmem_resp = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_output("reset_addr_cleared", a_pmem_address, 16'h0000);
        a_port_read = 2'b11;
        expect_txn("post_reset_fresh", 1'b0, 1, {16{8'h21}}, 4'b0001, 16'h0C00);
        a_port_read = '0;
        @(negedge clk);
        a_port_read = 2'b10;
        expect_txn("post_reset_port1", 1'b0, 2, {16{8'h22}}, 4'b0010, 16'h0D00);
        a_port_read = '0;
        @(negedge clk);

        // Stray pmem_resp while idle must be ignored; port_rdata always follows pmem_rdata.
        a_pmem_rdata = {8{16'hBEAD}};
        a_pmem_resp  = 1'b1;
        #1;
        check_output("stray_resp", a_port_resp, 2'b00);
        check_output("rdata_passthru", a_port_rdata, {8{16'hBEAD}});
        a_pmem_resp = 1'b0;
        @(negedge clk);
        check_output("stray_no_busy", {a_pmem_read, a_pmem_write}, 2'b00);
        a_port_write = 2'b01;
        a_port_address = {16'h0D00, 16'h0E00};
        expect_txn("after_stray", 1'b0, 1, {16{8'h33}}, 4'b0001, 16'h0E00);
        a_port_write = '0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/cache_arbiter_rr.md
CACHE_ARBITER_RR -- requirements
Module: cache_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of L1 requesters; legal range 2..8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte address width.
REQ-003 SHALL have parameter LINE_WIDTH, default 128, cache line width in bits.
REQ-004 SHALL have parameter RR_MODE, default 1; 1 = round-robin, 0 = fixed priority with highest port index highest.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port port_read  input  NUM_PORTS  per-port line read request, held until that port's resp.
REQ-008 SHALL have port port_write  input  NUM_PORTS  per-port line write request, held until that port's resp.
REQ-009 SHALL have port port_address  input  NUM_PORTS*ADDR_WIDTH  per-port address, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port port_wdata  input  NUM_PORTS*LINE_WIDTH  per-port write line, same packing.
REQ-011 SHALL have port port_resp  output  NUM_PORTS  per-port one-cycle completion pulse.
REQ-012 SHALL have port port_rdata  output  LINE_WIDTH  read line, broadcast to all ports.
REQ-013 SHALL have port pmem_read  output  1  downstream read strobe.
REQ-014 SHALL have port pmem_write  output  1  downstream write strobe.
REQ-015 SHALL have port pmem_address  output  ADDR_WIDTH  downstream address.
REQ-016 SHALL have port pmem_wdata  output  LINE_WIDTH  downstream write line.
REQ-017 SHALL have port pmem_resp  input  1  downstream completion pulse.
REQ-018 SHALL have port pmem_rdata  input  LINE_WIDTH  downstream read line, valid with pmem_resp.

Function
REQ-019 SHALL implement FSM IDLE -> BUSY -> RECOVER -> IDLE.
REQ-020 IDLE: SHALL sample requests; if any port_read|port_write is set, SHALL select one port, latch its one-hot grant, op, address and wdata, and go to BUSY next edge; else stay IDLE.
REQ-021 Selection SHALL use a round-robin pointer when RR_MODE=1: search starts at pointer, wraps from NUM_PORTS-1 to 0; the pointer SHALL update to (granted index + 1) mod NUM_PORTS on each grant.
REQ-022 When RR_MODE=0 the highest-indexed requesting port SHALL win and the pointer SHALL be unused.
REQ-023 A port asserting read and write together SHALL be treated as a write.
REQ-024 BUSY: SHALL drive pmem_read or pmem_write (exactly one) from the latched op, plus the latched pmem_address and pmem_wdata; inputs SHALL be ignored and changes to them SHALL not affect the transaction.
REQ-025 BUSY with pmem_resp=1: port_resp[grant] SHALL be 1 in that same cycle (combinational from pmem_resp), other bits 0; next state RECOVER.
REQ-026 port_rdata SHALL equal pmem_rdata combinationally at all times.
REQ-027 RECOVER: SHALL last exactly one cycle with pmem strobes 0 and port_resp 0, letting the finished port drop its request; next state IDLE.
REQ-028 Latency: request first visible at edge t -> pmem strobe asserted from cycle t+1; minimum back-to-back spacing is 3 cycles plus memory latency.
REQ-029 Outside BUSY, pmem_read, pmem_write and port_resp SHALL be 0; pmem_address and pmem_wdata SHALL hold their last latched values.
REQ-030 pmem_resp outside BUSY SHALL be ignored.
REQ-031 No starvation in RR mode: a continuously requesting port SHALL be granted within NUM_PORTS grants.

Reset
REQ-032 reset_n=0 SHALL asynchronously force IDLE, grant=0, pointer=0, pmem_read=0, pmem_write=0, port_resp=0, latched address=0, latched wdata=0.
REQ-033 Reset mid-BUSY SHALL abort the transaction with no port_resp; the first request after release SHALL be arbitrated fresh from pointer 0.

Verification
REQ-034 Single read: port1 read, addr 0x1230, pmem_resp 3 cycles later with rdata 0xA5.. -> pmem_read 1 for 3 cycles, port_resp=2'b10 once, port_rdata=0xA5...
REQ-035 Contention RR, NUM_PORTS=2, both read continuously -> grants alternate 0,1,0,1; pmem_address alternates between the two port addresses.
REQ-036 Fixed priority, RR_MODE=0, NUM_PORTS=4, ports 0 and 3 request -> port 3 served first and again before port 0 while it keeps requesting.
REQ-037 Port0 asserts read+write with wdata 0xFF.. -> pmem_write=1, pmem_read=0, pmem_wdata=0xFF...
REQ-038 reset_n low during BUSY -> pmem_read falls immediately without a clock edge, no port_resp; after release port1 request is granted before port0 when only port1 requests.
REQ-039 Stray pmem_resp during IDLE -> no port_resp and no state change.
